// File: rtl/iob_cpu_bus_split.sv
// CPU-to-IOb address decoder: routes one CPU request at a time to the slave
// picked by the address MSBs, with per-phase timeout and a sticky error report.

module iob_cpu_bus_split_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2,
  parameter int IDX    = 0
) (
  input  logic                en_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                ready_i,
  input  logic                rvalid_i,
  output logic                hit_o,
  output logic                avalid_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                ready_o,
  output logic                rvalid_o
);
  assign hit_o    = (sel_i == SEL_W'(IDX));
  assign avalid_o = en_i & hit_o;
  // Unselected ports drive zeros so nothing leaks onto idle slave buses.
  assign addr_o   = avalid_o ? addr_i  : '0;
  assign wdata_o  = avalid_o ? wdata_i : '0;
  assign wstrb_o  = avalid_o ? wstrb_i : '0;
  assign ready_o  = ready_i  & hit_o;
  assign rvalid_o = rvalid_i & hit_o;
endmodule

module iob_cpu_bus_split #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 2,
  parameter int IBUS_EN  = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         cpu_valid_i,
  input  logic                         cpu_instr_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  input  logic [DATA_W/8-1:0]          cpu_wstrb_i,
  output logic [DATA_W-1:0]            cpu_rdata_o,
  output logic                         cpu_ready_o,
  output logic [N_SLAVES-1:0]          s_avalid_o,
  output logic [N_SLAVES*ADDR_W-1:0]   s_addr_o,
  output logic [N_SLAVES*DATA_W-1:0]   s_wdata_o,
  output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb_o,
  input  logic [N_SLAVES-1:0]          s_ready_i,
  input  logic [N_SLAVES-1:0]          s_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  output logic                         err_o,
  output logic [ADDR_W-1:0]            err_addr_o,
  input  logic                         err_clr_i
);
  localparam int STRB_W = DATA_W/8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, RDWAIT, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [SEL_W-1:0]    sel_q, sel_d, sel_in;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                err_q, err_d, enter_err, tmo;
  logic [N_SLAVES-1:0] hit, rdy_m, rv_m;
  logic                sel_ready, sel_rvalid, req_st;
  logic [DATA_W-1:0]   sel_rdata;

  assign sel_in = ((IBUS_EN != 0) && cpu_instr_i) ? '0 : cpu_addr_i[ADDR_W-1 -: SEL_W];
  assign req_st = (state_q == REQ);
  assign tmo    = (TIMEOUT != 0) && (wcnt_q == CNT_W'(TIMEOUT));

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_port
    iob_cpu_bus_split_port #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .IDX(g)
    ) u_port (
      .en_i    (req_st),
      .sel_i   (sel_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .wstrb_i (wstrb_q),
      .ready_i (s_ready_i[g]),
      .rvalid_i(s_rvalid_i[g]),
      .hit_o   (hit[g]),
      .avalid_o(s_avalid_o[g]),
      .addr_o  (s_addr_o[g*ADDR_W +: ADDR_W]),
      .wdata_o (s_wdata_o[g*DATA_W +: DATA_W]),
      .wstrb_o (s_wstrb_o[g*STRB_W +: STRB_W]),
      .ready_o (rdy_m[g]),
      .rvalid_o(rv_m[g])
    );
  end

  assign sel_ready  = |rdy_m;
  assign sel_rvalid = |rv_m;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (hit[i]) sel_rdata = sel_rdata | s_rdata_i[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    sel_d      = sel_q;
    wcnt_d     = wcnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    enter_err  = 1'b0;
    if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    unique case (state_q)
      IDLE: if (cpu_valid_i) begin
        addr_d  = cpu_addr_i;
        wdata_d = cpu_wdata_i;
        wstrb_d = cpu_wstrb_i;
        sel_d   = sel_in;
        wcnt_d  = '0;
        if (32'(sel_in) >= 32'(N_SLAVES)) enter_err = 1'b1;
        else                              state_d   = REQ;
      end
      REQ: begin
        if (sel_ready) begin
          wcnt_d  = '0;
          state_d = (wstrb_q != '0) ? DONE : RDWAIT;
        end else if (tmo) enter_err = 1'b1;
        else if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
      end
      RDWAIT: begin
        if (sel_rvalid) begin
          rdata_d = sel_rdata;
          state_d = DONE;
        end else if (tmo) enter_err = 1'b1;
        else if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A fresh error overrides a same-cycle clear; the address sticks to the first failure.
    if (enter_err) begin
      state_d = ERR;
      rdata_d = '1;
      err_d   = 1'b1;
      if (!err_q || err_clr_i) err_addr_d = (state_q == IDLE) ? cpu_addr_i : addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      sel_q      <= '0;
      wcnt_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      sel_q      <= sel_d;
      wcnt_q     <= wcnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_ready_o = (state_q == DONE) || (state_q == ERR);
  assign cpu_rdata_o = rdata_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
endmodule
